// File: rtl/motor_pkg.sv
// motor_pkg: shared command/direction encodings and channel state type for motor_driver
package motor_pkg;
  localparam logic [1:0] CMD_STOP     = 2'b00;
  localparam logic [1:0] CMD_RIGHT    = 2'b01;
  localparam logic [1:0] CMD_LEFT     = 2'b10;
  localparam logic [1:0] CMD_STRAIGHT = 2'b11;
  localparam logic [1:0] DIR_COAST = 2'b00;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_BRAKE = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_DEAD} ch_state_t;
endpackage

// File: rtl/motor_channel.sv
// motor_channel: one wheel's FSM, soft-start ramp, reversal dead time and PWM compare
// MOTOR_BRAKE_EN: idle holds the bridge in short-brake (11) and coasts one period before driving
module motor_channel
  import motor_pkg::*;
#(
  parameter int PWM_BITS     = 10,
  parameter int RAMP_STEP    = 100,
  parameter int DEAD_PERIODS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_bnd,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  input  logic [1:0]          i_tgt_dir,
  input  logic [PWM_BITS-1:0] i_tgt_duty,
  output logic                o_pwm,
  output logic [1:0]          o_dir
);
  localparam int DW = $clog2(DEAD_PERIODS + 1);
  localparam logic [PWM_BITS:0] STEP = (PWM_BITS + 1)'(RAMP_STEP);
`ifdef MOTOR_BRAKE_EN
  localparam logic [1:0] IDLE_DIR = DIR_BRAKE;
`else
  localparam logic [1:0] IDLE_DIR = DIR_COAST;
`endif
  ch_state_t           r_state;
  logic [PWM_BITS-1:0] r_duty;
  logic [1:0]          r_dir;
  logic [DW-1:0]       r_dead;
  logic                r_pwm;
  logic                w_stop;
  logic [PWM_BITS:0]   w_sum;
  logic [PWM_BITS-1:0] w_ramp;
  logic [PWM_BITS-1:0] w_first;
  always_comb begin
    w_stop  = i_tgt_dir == DIR_COAST;
    w_sum   = {1'b0, r_duty} + STEP;
    w_ramp  = (w_sum > {1'b0, i_tgt_duty}) ? i_tgt_duty : w_sum[PWM_BITS-1:0];
    w_first = (STEP > {1'b0, i_tgt_duty}) ? i_tgt_duty : STEP[PWM_BITS-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_duty  <= '0;
      r_dir   <= DIR_COAST;
      r_dead  <= '0;
      r_pwm   <= 1'b0;
    end else begin
      r_pwm <= r_duty > i_pwm_cnt;
      if (i_bnd) begin
        case (r_state)
          ST_IDLE: begin
            if (w_stop) r_dir <= IDLE_DIR;
            // leaving short-brake always passes through one coast period
            else if (r_dir == DIR_BRAKE) r_dir <= DIR_COAST;
            else begin
              r_dir   <= i_tgt_dir;
              r_duty  <= w_first;
              r_state <= ST_DRIVE;
            end
          end
          ST_DRIVE: begin
            if (w_stop) begin
              r_duty  <= '0;
              r_dir   <= IDLE_DIR;
              r_state <= ST_IDLE;
            end else if (i_tgt_dir != r_dir) begin
              r_duty  <= '0;
              r_dir   <= DIR_COAST;
              r_dead  <= DW'(DEAD_PERIODS - 1);
              r_state <= ST_DEAD;
            end else r_duty <= (i_tgt_duty > r_duty) ? w_ramp : i_tgt_duty;
          end
          ST_DEAD: begin
            if (w_stop) begin
              r_dir   <= IDLE_DIR;
              r_state <= ST_IDLE;
            end else if (r_dead == '0) begin
              r_dir   <= i_tgt_dir;
              r_duty  <= w_first;
              r_state <= ST_DRIVE;
            end else r_dead <= r_dead - 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end
  assign o_pwm = r_pwm;
  assign o_dir = r_dir;
endmodule

// File: rtl/motor_driver.sv
// motor_driver: tracker command register/decode and shared PWM counter feeding two wheel channels
// MOTOR_BRAKE_EN (in motor_channel) selects short-brake idle
module motor_driver
  import motor_pkg::*;
#(
  parameter int PWM_BITS     = 10,
  parameter int DUTY_FAST    = 800,
  parameter int DUTY_TURN    = 400,
  parameter int RAMP_STEP    = 100,
  parameter int DEAD_PERIODS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_move,
  input  logic [1:0] state,
  output logic       left_pwm,
  output logic       right_pwm,
  output logic [1:0] left_dir,
  output logic [1:0] right_dir
);
  localparam logic [PWM_BITS-1:0] FAST = PWM_BITS'(DUTY_FAST);
  localparam logic [PWM_BITS-1:0] TURN = PWM_BITS'(DUTY_TURN);
  logic                r_en;
  logic [1:0]          r_cmd;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [1:0]          w_cmd;
  logic                w_bnd;
  logic [1:0]          w_l_dir;
  logic [1:0]          w_r_dir;
  logic [PWM_BITS-1:0] w_l_duty;
  logic [PWM_BITS-1:0] w_r_duty;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en      <= 1'b0;
      r_cmd     <= CMD_STOP;
      r_pwm_cnt <= '0;
    end else begin
      r_en      <= start_move;
      r_cmd     <= state;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end
  always_comb begin
    w_cmd    = r_en ? r_cmd : CMD_STOP;
    w_bnd    = &r_pwm_cnt;
    w_l_dir  = (w_cmd == CMD_STOP) ? DIR_COAST : (w_cmd == CMD_LEFT) ? DIR_REV : DIR_FWD;
    w_r_dir  = (w_cmd == CMD_STOP) ? DIR_COAST : (w_cmd == CMD_RIGHT) ? DIR_REV : DIR_FWD;
    w_l_duty = (w_cmd == CMD_STOP) ? '0 : (w_cmd == CMD_LEFT) ? TURN : FAST;
    w_r_duty = (w_cmd == CMD_STOP) ? '0 : (w_cmd == CMD_RIGHT) ? TURN : FAST;
  end
  motor_channel #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP), .DEAD_PERIODS(DEAD_PERIODS)) u_left (
    .clk(clk), .reset(reset), .i_bnd(w_bnd), .i_pwm_cnt(r_pwm_cnt),
    .i_tgt_dir(w_l_dir), .i_tgt_duty(w_l_duty), .o_pwm(left_pwm), .o_dir(left_dir)
  );
  motor_channel #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP), .DEAD_PERIODS(DEAD_PERIODS)) u_right (
    .clk(clk), .reset(reset), .i_bnd(w_bnd), .i_pwm_cnt(r_pwm_cnt),
    .i_tgt_dir(w_r_dir), .i_tgt_duty(w_r_duty), .o_pwm(right_pwm), .o_dir(right_dir)
  );
endmodule

// File: tb/tb_motor_driver.sv
// tb_motor_driver: per-period scoreboard of dir and PWM high count for both wheels, plus reset snapshots
module tb_motor_driver;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_move = 1'b0;
  logic [1:0] state = 2'b00;
  logic       left_pwm, right_pwm;
  logic [1:0] left_dir, right_dir;
  typedef struct {
    logic [1:0] ld;
    int         lh;
    logic [1:0] rd;
    int         rh;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int total = 0, bad = 0, win = 0, wcnt = 0, lh = 0, rh = 0;
  logic [1:0] ld, rd;
  logic mon_on = 1'b0, snap_req = 1'b0, done = 1'b0;
  int sn_lp, sn_rp, sn_ld, sn_rd, sn_cnt;
  motor_driver #(.PWM_BITS(4), .DUTY_FAST(12), .DUTY_TURN(6), .RAMP_STEP(4), .DEAD_PERIODS(2)) dut (
    .clk(clk), .reset(reset), .start_move(start_move), .state(state),
    .left_pwm(left_pwm), .right_pwm(right_pwm), .left_dir(left_dir), .right_dir(right_dir)
  );
  always #5 clk = ~clk;
  task automatic push(input logic [1:0] eld, input int elh, input logic [1:0] erd, input int erh);
    exp_t x;
    x.ld = eld; x.lh = elh; x.rd = erd; x.rh = erh;
    q.push_back(x);
  endtask
  task automatic step(input int off, input logic en, input logic [1:0] st,
                      input logic [1:0] eld, input int elh, input logic [1:0] erd, input int erh);
    repeat (off) @(negedge clk);
    start_move = en;
    state = st;
    push(eld, elh, erd, erh);
    repeat (16 - off) @(negedge clk);
  endtask
  task automatic snap(input int lp, input int rp, input int l_d, input int r_d, input int c);
    sn_lp = lp; sn_rp = rp; sn_ld = l_d; sn_rd = r_d; sn_cnt = c;
    snap_req = 1'b1;
  endtask
  task automatic cmp(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s win=%0d got=%0d want=%0d", nm, win, got, want);
    end
  endtask
  initial begin
    @(negedge clk);
    snap(0, 0, 0, 0, 0);
    @(negedge clk);
    snap_req = 1'b0;
    reset = 1'b0;
    mon_on = 1'b1;
    push(2'b00, 0, 2'b00, 0);
    step(0, 1'b0, 2'b11, 2'b00, 0,  2'b00, 0);
    step(0, 1'b0, 2'b11, 2'b00, 0,  2'b00, 0);
    step(0, 1'b1, 2'b11, 2'b10, 4,  2'b10, 4);
    step(0, 1'b1, 2'b11, 2'b10, 8,  2'b10, 8);
    step(0, 1'b1, 2'b11, 2'b10, 12, 2'b10, 12);
    step(0, 1'b1, 2'b11, 2'b10, 12, 2'b10, 12);
    step(5, 1'b1, 2'b10, 2'b00, 0,  2'b10, 12);
    step(0, 1'b1, 2'b11, 2'b00, 0,  2'b10, 12);
    step(0, 1'b1, 2'b10, 2'b01, 4,  2'b10, 12);
    step(0, 1'b1, 2'b10, 2'b01, 6,  2'b10, 12);
    step(0, 1'b1, 2'b11, 2'b00, 0,  2'b10, 12);
    step(0, 1'b1, 2'b11, 2'b00, 0,  2'b10, 12);
    step(0, 1'b1, 2'b11, 2'b10, 4,  2'b10, 12);
    step(0, 1'b1, 2'b11, 2'b10, 8,  2'b10, 12);
    step(5, 1'b1, 2'b00, 2'b00, 0,  2'b00, 0);
    step(0, 1'b1, 2'b01, 2'b10, 4,  2'b01, 4);
    step(0, 1'b1, 2'b01, 2'b10, 8,  2'b01, 6);
    step(0, 1'b1, 2'b11, 2'b10, 12, 2'b00, 0);
    step(0, 1'b1, 2'b11, 2'b10, 12, 2'b00, 0);
    step(0, 1'b1, 2'b11, 2'b10, 12, 2'b10, 4);
    step(3, 1'b1, 2'b01, 2'b10, 12, 2'b00, 0);
    step(0, 1'b0, 2'b00, 2'b00, 0,  2'b00, 0);
    repeat (8) @(negedge clk);
    mon_on = 1'b0;
    start_move = 1'b1;
    state = 2'b11;
    repeat (9) @(negedge clk);
    snap(1, 1, 2, 2, 2);
    @(negedge clk);
    reset = 1'b1;
    snap(0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    snap_req = 1'b0;
    mon_on = 1'b1;
    push(2'b00, 0, 2'b00, 0);
    push(2'b10, 4, 2'b10, 4);
    push(2'b10, 8, 2'b10, 8);
    repeat (40) @(negedge clk);
    mon_on = 1'b0;
    repeat (16) @(negedge clk);
    done = 1'b1;
  end
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (snap_req) begin
        cmp("snap_left_pwm", int'(left_pwm), sn_lp);
        cmp("snap_right_pwm", int'(right_pwm), sn_rp);
        cmp("snap_left_dir", int'(left_dir), sn_ld);
        cmp("snap_right_dir", int'(right_dir), sn_rd);
        cmp("snap_pwm_cnt", int'(dut.r_pwm_cnt), sn_cnt);
      end
      if (done) begin
        cmp("leftover_expectations", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
      if (mon_on || wcnt != 0) begin
        wcnt++;
        if (wcnt == 1) begin
          ld = left_dir;
          rd = right_dir;
          lh = 0;
          rh = 0;
        end
        lh += int'(left_pwm);
        rh += int'(right_pwm);
        if (wcnt == 16) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL no_expectation win=%0d got=window want=none", win);
          end else begin
            e = q.pop_front();
            cmp("left_dir", int'(ld), int'(e.ld));
            cmp("left_high", lh, e.lh);
            cmp("right_dir", int'(rd), int'(e.rd));
            cmp("right_high", rh, e.rh);
          end
          wcnt = 0;
          win++;
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/motor_driver.md
Name: motor_driver

Overview:
- Consumes the 2-bit drive command produced by the line-tracker sensor policy.
- Generates PWM and H-bridge direction pins (L298N-style IN1/IN2) for the left and right wheel motors.
- Provides soft-start ramping, glitch-free period-aligned updates, and a dead interval on any direction reversal.
- Sits between the tracker sensor block and the board motor pins.

Parameters:
- PWM_BITS, 10: PWM counter width; period = 2^PWM_BITS clk cycles.
- DUTY_FAST, 800: duty for a forward-driving wheel. Must be < 2^PWM_BITS.
- DUTY_TURN, 400: duty for the reversing inner wheel during a turn. Must be < 2^PWM_BITS.
- RAMP_STEP, 100: maximum duty increase per PWM period.
- DEAD_PERIODS, 4: whole PWM periods of coast inserted before a direction flip. Must be ≥ 1.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- start_move, input, 1: enable. When 0, the command is treated as stop.
- state, input, 2: drive command. 00 = stop, 01 = turn_right, 10 = turn_left, 11 = go_straight.
- left_pwm, output, 1: left motor enable PWM.
- right_pwm, output, 1: right motor enable PWM.
- left_dir, output, 2: left {IN1,IN2}. 10 = forward, 01 = reverse, 00 = coast.
- right_dir, output, 2: right {IN1,IN2}, same encoding as left_dir.

Behaviour:
- **Reset** (synchronous, active-high; one clk edge with reset=1): pwm_cnt=0, both channels IDLE, cur_duty=0, dir=00, left_pwm=right_pwm=0. Reset mid-period takes effect on the next edge, with no completion of the current period.
- **Command register:** {start_move,state} is registered every cycle, giving 1 cycle of input latency.
- **Command decode** into per-wheel target (dir, duty):
  - stop or start_move=0: both 00, duty 0.
  - go_straight: both forward, DUTY_FAST.
  - turn_left: left reverse DUTY_TURN; right forward DUTY_FAST.
  - turn_right: left forward DUTY_FAST; right reverse DUTY_TURN.
- **PWM counter:** pwm_cnt is free-running and wraps from 2^PWM_BITS-1 to 0. A period boundary is the cycle where pwm_cnt == 2^PWM_BITS-1.
- **Update timing:** channel FSMs, cur_duty and dir update only on a boundary cycle. A command change mid-period never alters the current period's pulse width.
- **PWM output:** pwm = registered (cur_duty > pwm_cnt).
  - duty 0 gives a constant low output.
  - duty 2^PWM_BITS-1 gives high for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
- **Per-channel FSM:**
  - IDLE: dir=00, duty=0. If the target is non-stop: dir←target_dir, cur_duty←min(RAMP_STEP, target_duty), go to DRIVE.
  - DRIVE, target stop: cur_duty←0, dir←00, go to IDLE.
  - DRIVE, target dir opposite current: cur_duty←0, dir←00, dead_cnt←DEAD_PERIODS-1, go to DEAD.
  - DRIVE, same dir, target_duty > cur_duty: cur_duty←min(cur_duty+RAMP_STEP, target_duty), computed at PWM_BITS+1 width and saturating.
  - DRIVE, same dir, target_duty ≤ cur_duty: cur_duty←target_duty immediately, with no down-ramp.
  - DEAD: dir=00, duty=0.
    - Target stop: go to IDLE.
    - Else if dead_cnt==0: dir←target_dir, cur_duty←min(RAMP_STEP, target_duty), go to DRIVE.
    - Else dead_cnt decrements.
    - A target that reverts to the pre-flip direction still completes the dead interval.
- **Simultaneous events:** reset wins over everything. The boundary cycle uses the command registered on the previous cycle.

Optional Feature:
- Macro: MOTOR_BRAKE_EN.
- Defined: IDLE drives dir=11 (short-brake) instead of 00. DEAD still uses 00. Entering DRIVE from IDLE passes through one coast boundary: IDLE(11) → dir 00 for one period → DRIVE.
- Undefined: IDLE drives dir=00 and goes directly to DRIVE.

Decomposition:
- Shared package motor_pkg:
  - command encodings CMD_STOP/CMD_RIGHT/CMD_LEFT/CMD_STRAIGHT (matching tracker encodings 00/01/10/11).
  - dir encodings DIR_COAST/DIR_FWD/DIR_REV/DIR_BRAKE.
  - channel FSM state typedef (IDLE/DRIVE/DEAD).
- Sub-module motor_channel (instantiated twice) holds one wheel's FSM, ramp, dead counter and PWM compare.
- The top level holds the command register, decode and the shared pwm_cnt.

Test Plan (PWM_BITS=4, DUTY_FAST=12, DUTY_TURN=6, RAMP_STEP=4, DEAD_PERIODS=2):
- **Soft start:** reset, start_move=1, state=11 → both dir=10; duty 4, 8, 12 on successive boundaries; then 12 high cycles of every 16.
- **Enable gate:** start_move=0, state=11 → both channels stay IDLE, pwm=0, dir=00 indefinitely.
- **Reversal with dead time:** steady go_straight, then state=10 → left: dir=00, pwm=0 for 2 periods, then dir=01 with duty 4 then 6 (clamped); right unchanged at 10/12.
- **Stop mid-ramp:** stop at duty 8 → next boundary duty 0, dir=00 (11 with MOTOR_BRAKE_EN).
- **Mid-period change:** command changes at pwm_cnt=5 → current pulse width unchanged; new duty applies from the next period.
- **Reset while high:** assert reset while pwm=1 → next edge pwm=0, dirs 00, pwm_cnt 0; after release, ramp restarts at 4.
